uart_fifo_wr_arb_ctrl: RTL and testbench
========================================

# uart_fifo_wr_arb_ctrl

Write-side controller and two-requester arbiter for the UART async FIFO, running entirely in the write clock domain. It grants the FIFO write port to two requesters in round-robin order and drives the dual-port memory write channel: pointer, data and valid. It generates the binary/Gray write pointer, synchronises the read-domain Gray pointer, and produces full, almost-full and fill-level status. It sits between the UART RX/loopback sources and the FIFO storage array.

## Interface
- DLY, 1, simulation delay applied to every registered assignment
- FIFO_WIDTH, 8, data width
- FIFO_DEPTH, 8, number of entries; power of two, ≥4
- ADDR, $clog2(FIFO_DEPTH), memory address width
- AFULL_THRESH, FIFO_DEPTH-2, level at or above which almost_full_o asserts

Ports:
- rst_n_i  in  1  reset, asynchronous, active-low
- wr_clk_i  in  1  write-domain clock
- req0_valid_i  in  1  requester 0 has data
- req0_data_i  in  FIFO_WIDTH  requester 0 data
- req0_ready_o  out  1  requester 0 accepted this cycle
- req1_valid_i  in  1  requester 1 has data
- req1_data_i  in  FIFO_WIDTH  requester 1 data
- req1_ready_o  out  1  requester 1 accepted this cycle
- rd_gray_ptr_i  in  ADDR+1  read pointer, Gray code, read clock domain
- wr_gray_ptr_o  out  ADDR+1  registered write pointer, Gray code, to read domain
- mem_wr_valid_o  out  1  memory write strobe
- mem_wr_ptr_o  out  ADDR  memory write address
- mem_wr_data_o  out  FIFO_WIDTH  memory write data
- full_o  out  1  FIFO full
- almost_full_o  out  1  level ≥ AFULL_THRESH
- wr_level_o  out  ADDR+1  fill level as seen from the write domain (0..FIFO_DEPTH)

## Operation
- Internal state: wr_bin and wr_gray, both ADDR+1 bits; rd_sync1/rd_sync2, a 2-flop synchroniser on rd_gray_ptr_i; prio, 1 bit, 0 = requester 0 favoured.
- rd_bin = gray2bin(rd_sync2).
- wr_level_o = wr_bin − rd_bin, modulo 2^(ADDR+1).
- full_o = (wr_gray == {~rd_sync2[ADDR:ADDR-1], rd_sync2[ADDR-2:0]}).
- almost_full_o = (wr_level_o ≥ AFULL_THRESH).
- Grant is combinational:
  - If only one valid is high, that requester is granted.
  - If both are high, requester `prio` is granted.
  - reqN_ready_o = grantN & !full_o.
- Accept = any reqN_valid_i & reqN_ready_o.
- mem_wr_valid_o = accept.
- mem_wr_ptr_o = wr_bin[ADDR-1:0].
- mem_wr_data_o = data of the granted requester; all-zero when no grant.
- On an accept edge:
  - wr_bin ← wr_bin+1, wrapping at 2^(ADDR+1).
  - wr_gray ← bin2gray(wr_bin+1).
  - prio ← the non-accepted requester index.
- With no accept, all state holds.
- When full_o is high, neither ready asserts; requesters hold valid and data until ready. Overflow is therefore impossible.
- Reset asserted, including mid-operation:
  - wr_bin, wr_gray, rd_sync1 and rd_sync2 clear to 0; prio clears to 0.
  - Outputs: full_o=0, almost_full_o=0, wr_level_o=0, wr_gray_ptr_o=0, mem_wr_valid_o=0, both readies 0.
  - Memory contents are don't-care.

## Timing
- Zero-latency write. The memory captures mem_wr_data_o on the same wr_clk_i edge that advances wr_bin; readyN_o is valid in the same cycle as validN_i.
- A write at edge t is reflected in wr_level_o, full_o and almost_full_o immediately after edge t.
- A change on rd_gray_ptr_i is reflected after the second following wr_clk_i edge. full_o and the level are therefore pessimistic by up to 2–3 write clocks and can never be optimistic.
- wr_gray_ptr_o is a direct flop output: no combinational path, one bit changes per increment.
- Back-to-back accepts at one per clock are required while not full.

## Structure
- Package uart_fifo_pkg:
  - bin2gray and gray2bin functions, parameterised by width.
  - Default depth and width constants, shared with the read-side controller.
- Sub-module gray_sync_2ff: a parameterised-width 2-flop synchroniser with async active-low reset. The read-side controller reuses it.

## Test plan
All scenarios use FIFO_DEPTH=8.
- **Reset values.** Reset, then release with both valids low → all outputs 0, and wr_gray_ptr_o stays 0 across 10 clocks.
- **Single requester fills the FIFO.** Hold req0_valid_i=1 with data 0x10..0x17 and rd_gray_ptr_i=0 →
  - 8 accepts at addresses 0..7.
  - almost_full_o rises after the 6th write; full_o rises after the 8th.
  - req0_ready_o falls to 0; wr_level_o=8.
- **Round-robin.** Both valids high continuously → grants alternate 0,1,0,1; mem_wr_data_o alternates between the two data buses.
- **Full release.** From full, set rd_gray_ptr_i=bin2gray(1) → full_o drops exactly 2 edges later; one more write is accepted; full_o reasserts.
- **Wrap-around.** Perform 20 writes, advancing rd_gray_ptr_i to match → wr_bin wraps 15→0; wr_gray_ptr_o changes exactly one bit per write; wr_level_o stays correct.
- **Reset mid-burst.** Assert rst_n_i low during the 4th write → all outputs clear asynchronously; the first write after release lands at address 0.

Source files
------------

// File: rtl/uart_fifo_pkg.sv
// Shared definitions for the UART async FIFO: default geometry and Gray-code helpers
// used by both the write-side and read-side controllers.
package uart_fifo_pkg;

    localparam int FIFO_WIDTH_DEF = 8;
    localparam int FIFO_DEPTH_DEF = 8;

    // Helpers work on a fixed wide vector; callers zero-extend in and truncate out,
    // which leaves the Gray/binary mapping of any narrower width unchanged.
    localparam int PTR_MAX_W = 16;
    typedef logic [PTR_MAX_W-1:0] ptr_t;

    function automatic ptr_t bin2gray(input ptr_t bin);
        return bin ^ (bin >> 1);
    endfunction

    function automatic ptr_t gray2bin(input ptr_t gray);
        ptr_t bin;
        bin[PTR_MAX_W-1] = gray[PTR_MAX_W-1];
        for (int i = PTR_MAX_W - 2; i >= 0; i--) begin
            bin[i] = bin[i+1] ^ gray[i];
        end
        return bin;
    endfunction

endpackage

// File: rtl/gray_sync_2ff.sv
// Two-flop synchroniser for a Gray-coded pointer crossing into the local clock domain.
module gray_sync_2ff #(
    parameter int WIDTH = 4
) (
    input  logic             rst_n_i,
    input  logic             clk_i,
    input  logic [WIDTH-1:0] d_i,
    output logic [WIDTH-1:0] q_o
);

    logic [WIDTH-1:0] r_sync1;
    logic [WIDTH-1:0] r_sync2;

    // NOTE: flops use non-blocking assignments so r_sync2 takes the old r_sync1, forming two stages.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            r_sync1 <= '0;
            r_sync2 <= '0;
        end else begin
            r_sync1 <= d_i;
            r_sync2 <= r_sync1;
        end
    end

    assign q_o = r_sync2;

endmodule

// File: rtl/uart_fifo_wr_arb_ctrl.sv
// Write-side controller of the UART async FIFO: round-robin arbitration of two
// requesters onto the memory write port, write pointer generation and fill status.
module uart_fifo_wr_arb_ctrl
    import uart_fifo_pkg::*;
#(
    parameter int FIFO_WIDTH   = FIFO_WIDTH_DEF,
    parameter int FIFO_DEPTH   = FIFO_DEPTH_DEF,
    parameter int ADDR         = $clog2(FIFO_DEPTH),
    parameter int AFULL_THRESH = FIFO_DEPTH - 2
) (
    input  logic                  rst_n_i,
    input  logic                  wr_clk_i,
    input  logic                  req0_valid_i,
    input  logic [FIFO_WIDTH-1:0] req0_data_i,
    output logic                  req0_ready_o,
    input  logic                  req1_valid_i,
    input  logic [FIFO_WIDTH-1:0] req1_data_i,
    output logic                  req1_ready_o,
    input  logic [ADDR:0]         rd_gray_ptr_i,
    output logic [ADDR:0]         wr_gray_ptr_o,
    output logic                  mem_wr_valid_o,
    output logic [ADDR-1:0]       mem_wr_ptr_o,
    output logic [FIFO_WIDTH-1:0] mem_wr_data_o,
    output logic                  full_o,
    output logic                  almost_full_o,
    output logic [ADDR:0]         wr_level_o
);

    localparam int PW = ADDR + 1;
    localparam logic [PW-1:0] AFULL_LVL = PW'(AFULL_THRESH);

    logic [PW-1:0] r_wr_bin;
    logic [PW-1:0] r_wr_gray;
    logic          r_prio;

    logic [PW-1:0] w_rd_sync;
    logic [PW-1:0] w_rd_bin;
    logic [PW-1:0] w_wr_bin_nxt;
    logic [PW-1:0] w_level;
    logic          w_full;
    logic          w_grant0;
    logic          w_grant1;
    logic          w_accept;

    gray_sync_2ff #(
        .WIDTH (PW)
    ) u_rd_sync (
        .rst_n_i (rst_n_i),
        .clk_i   (wr_clk_i),
        .d_i     (rd_gray_ptr_i),
        .q_o     (w_rd_sync)
    );

    assign w_rd_bin     = PW'(gray2bin(PTR_MAX_W'(w_rd_sync)));
    assign w_wr_bin_nxt = r_wr_bin + PW'(1);
    assign w_level      = r_wr_bin - w_rd_bin;
    // Full when the pointers differ by exactly one lap: top two Gray bits inverted.
    assign w_full       = (r_wr_gray == {~w_rd_sync[ADDR:ADDR-1], w_rd_sync[ADDR-2:0]});

    // NOTE: every always_comb output gets a default first, so no path can infer a latch.
    always_comb begin
        w_grant0 = 1'b0;
        w_grant1 = 1'b0;
        if (req0_valid_i && (!req1_valid_i || !r_prio)) begin
            w_grant0 = 1'b1;
        end else if (req1_valid_i) begin
            w_grant1 = 1'b1;
        end
    end

    // Readies are gated by reset so nothing is accepted while the pointers are held clear.
    assign req0_ready_o   = w_grant0 & ~w_full & rst_n_i;
    assign req1_ready_o   = w_grant1 & ~w_full & rst_n_i;
    assign w_accept       = (req0_valid_i & req0_ready_o) | (req1_valid_i & req1_ready_o);

    assign mem_wr_valid_o = w_accept;
    assign mem_wr_ptr_o   = r_wr_bin[ADDR-1:0];
    assign mem_wr_data_o  = w_grant0 ? req0_data_i :
                            w_grant1 ? req1_data_i : '0;

    assign full_o         = w_full;
    assign almost_full_o  = (w_level >= AFULL_LVL);
    assign wr_level_o     = w_level;
    assign wr_gray_ptr_o  = r_wr_gray;

    always_ff @(posedge wr_clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            r_wr_bin  <= '0;
            r_wr_gray <= '0;
            r_prio    <= 1'b0;
        end else if (w_accept) begin
            r_wr_bin  <= w_wr_bin_nxt;
            r_wr_gray <= PW'(bin2gray(PTR_MAX_W'(w_wr_bin_nxt)));
            r_prio    <= w_grant0;
        end
    end

endmodule

// File: tb/tb_uart_fifo_wr_arb_ctrl.sv
// Self-checking bench for uart_fifo_wr_arb_ctrl: directed scenarios plus randomised
// traffic compared against a count-based model of the FIFO write side.
module tb_uart_fifo_wr_arb_ctrl;

    localparam int W     = 8;
    localparam int DEPTH = 8;
    localparam int AW    = 3;

    logic          rst_n_i;
    logic          wr_clk_i;
    logic          req0_valid_i;
    logic [W-1:0]  req0_data_i;
    logic          req0_ready_o;
    logic          req1_valid_i;
    logic [W-1:0]  req1_data_i;
    logic          req1_ready_o;
    logic [AW:0]   rd_gray_ptr_i;
    logic [AW:0]   wr_gray_ptr_o;
    logic          mem_wr_valid_o;
    logic [AW-1:0] mem_wr_ptr_o;
    logic [W-1:0]  mem_wr_data_o;
    logic          full_o;
    logic          almost_full_o;
    logic [AW:0]   wr_level_o;

    uart_fifo_wr_arb_ctrl #(
        .FIFO_WIDTH (W),
        .FIFO_DEPTH (DEPTH)
    ) dut (
        .rst_n_i        (rst_n_i),
        .wr_clk_i       (wr_clk_i),
        .req0_valid_i   (req0_valid_i),
        .req0_data_i    (req0_data_i),
        .req0_ready_o   (req0_ready_o),
        .req1_valid_i   (req1_valid_i),
        .req1_data_i    (req1_data_i),
        .req1_ready_o   (req1_ready_o),
        .rd_gray_ptr_i  (rd_gray_ptr_i),
        .wr_gray_ptr_o  (wr_gray_ptr_o),
        .mem_wr_valid_o (mem_wr_valid_o),
        .mem_wr_ptr_o   (mem_wr_ptr_o),
        .mem_wr_data_o  (mem_wr_data_o),
        .full_o         (full_o),
        .almost_full_o  (almost_full_o),
        .wr_level_o     (wr_level_o)
    );

    initial wr_clk_i = 1'b0;
    always #5 wr_clk_i = ~wr_clk_i;

    int n_checks = 0;
    int n_errors = 0;

    // Model: total writes accepted, total entries the reader has released, and the
    // reader count as the write domain sees it one and two edges later.
    int wr_cnt   = 0;
    int rd_cnt   = 0;
    int seen1    = 0;
    int seen2    = 0;
    int last_win = 1;
    int step_win = -1;
    bit step_acc = 1'b0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got=0x%0h expected=0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [AW:0] to_gray(input int n);
        logic [AW:0] b;
        b = n[AW:0];
        return b ^ (b >> 1);
    endfunction

    task automatic model_reset();
        wr_cnt   = 0;
        rd_cnt   = 0;
        seen1    = 0;
        seen2    = 0;
        last_win = 1;
    endtask

    // One write-clock cycle: drive after the falling edge, check mid-cycle, then advance the model.
    task automatic step(input bit v0, input logic [W-1:0] d0, input bit v1, input logic [W-1:0] d1);
        int  lvl;
        int  win;
        bit  full_e;
        bit  acc;
        logic [W-1:0] data_e;
        @(negedge wr_clk_i);
        req0_valid_i  = v0;
        req0_data_i   = d0;
        req1_valid_i  = v1;
        req1_data_i   = d1;
        rd_gray_ptr_i = to_gray(rd_cnt);
        #1;
        lvl    = wr_cnt - seen2;
        full_e = (lvl == DEPTH);
        win    = -1;
        if (v0 && (!v1 || last_win == 1)) win = 0;
        else if (v1) win = 1;
        acc    = (win >= 0) && !full_e;
        data_e = (win == 0) ? d0 : (win == 1) ? d1 : '0;
        check("ready0",    32'(req0_ready_o),   32'(win == 0 && !full_e));
        check("ready1",    32'(req1_ready_o),   32'(win == 1 && !full_e));
        check("wr_valid",  32'(mem_wr_valid_o), 32'(acc));
        check("wr_ptr",    32'(mem_wr_ptr_o),   32'(wr_cnt % DEPTH));
        check("wr_data",   32'(mem_wr_data_o),  32'(data_e));
        check("full",      32'(full_o),         32'(full_e));
        check("afull",     32'(almost_full_o),  32'(lvl >= DEPTH - 2));
        check("level",     32'(wr_level_o),     32'(lvl));
        check("wr_gray",   32'(wr_gray_ptr_o),  32'(to_gray(wr_cnt)));
        @(posedge wr_clk_i);
        if (acc) begin
            wr_cnt++;
            last_win = win;
        end
        seen2    = seen1;
        seen1    = rd_cnt;
        step_win = win;
        step_acc = acc;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b0, '0, 1'b0, '0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1);
    end

    initial begin
        logic [AW:0] g_prev;
        bit p0, p1;
        logic [W-1:0] pd0, pd1;
        int  wins[$];

        // Reset values, with a requester already asserting during reset.
        rst_n_i       = 1'b0;
        req0_valid_i  = 1'b1;
        req0_data_i   = 8'h55;
        req1_valid_i  = 1'b1;
        req1_data_i   = 8'h66;
        rd_gray_ptr_i = '0;
        #3;
        check("rst_ready0", 32'(req0_ready_o),   32'(0));
        check("rst_ready1", 32'(req1_ready_o),   32'(0));
        check("rst_wvalid", 32'(mem_wr_valid_o), 32'(0));
        check("rst_full",   32'(full_o),         32'(0));
        check("rst_afull",  32'(almost_full_o),  32'(0));
        check("rst_level",  32'(wr_level_o),     32'(0));
        check("rst_gray",   32'(wr_gray_ptr_o),  32'(0));
        #20;
        req0_valid_i = 1'b0;
        req1_valid_i = 1'b0;
        @(negedge wr_clk_i);
        rst_n_i = 1'b1;
        model_reset();
        idle(10);

        // Single requester fills the FIFO while the reader stays at zero.
        for (int k = 0; k < 10; k++) step(1'b1, 8'(8'h10 + wr_cnt), 1'b0, '0);
        check("fill_count", 32'(wr_cnt),  32'(8));
        #1;
        check("fill_full",  32'(full_o),  32'(1));
        check("fill_level", 32'(wr_level_o), 32'(8));

        // Full release: one entry freed shows up two edges later, one more write fills again.
        rd_cnt = 1;
        for (int k = 0; k < 4; k++) step(1'b1, 8'(8'h10 + wr_cnt), 1'b0, '0);
        check("release_count", 32'(wr_cnt), 32'(9));

        // Drain, then round-robin with both requesters always valid.
        rd_cnt = wr_cnt;
        idle(3);
        for (int k = 0; k < 6; k++) begin
            step(1'b1, 8'(8'hA0 + k), 1'b1, 8'(8'hB0 + k));
            wins.push_back(step_win);
            rd_cnt = wr_cnt;
        end
        for (int k = 1; k < 6; k++) check("rr_alternate", 32'(wins[k]), 32'(1 - wins[k-1]));

        // Wrap-around: reader keeps pace so every cycle writes; pointer crosses 15->0.
        idle(3);
        #1;
        g_prev = wr_gray_ptr_o;
        for (int k = 0; k < 20; k++) begin
            step(1'b1, 8'($urandom), 1'b0, '0);
            rd_cnt = wr_cnt;
            #1;
            check("gray_one_bit", 32'($countones(wr_gray_ptr_o ^ g_prev)), 32'(1));
            g_prev = wr_gray_ptr_o;
        end

        // Randomised traffic: requesters hold valid/data until accepted, reader lags randomly.
        p0 = 1'b0;
        p1 = 1'b0;
        pd0 = '0;
        pd1 = '0;
        for (int k = 0; k < 400; k++) begin
            if (!p0 && ($urandom_range(0, 2) != 0)) begin p0 = 1'b1; pd0 = 8'($urandom); end
            if (!p1 && ($urandom_range(0, 2) != 0)) begin p1 = 1'b1; pd1 = 8'($urandom); end
            step(p0, pd0, p1, pd1);
            if (step_acc && step_win == 0) p0 = 1'b0;
            if (step_acc && step_win == 1) p1 = 1'b0;
            if (rd_cnt < wr_cnt && ($urandom_range(0, 3) == 0)) rd_cnt++;
        end

        // Reset mid-burst: assert during the 4th write, outputs clear without a clock edge.
        rd_cnt = wr_cnt;
        idle(3);
        for (int k = 0; k < 3; k++) step(1'b1, 8'(8'hC0 + k), 1'b0, '0);
        @(negedge wr_clk_i);
        req0_valid_i = 1'b1;
        req0_data_i  = 8'hC3;
        #1;
        rst_n_i = 1'b0;
        #1;
        check("mid_rst_ready0", 32'(req0_ready_o),   32'(0));
        check("mid_rst_wvalid", 32'(mem_wr_valid_o), 32'(0));
        check("mid_rst_full",   32'(full_o),         32'(0));
        check("mid_rst_afull",  32'(almost_full_o),  32'(0));
        check("mid_rst_level",  32'(wr_level_o),     32'(0));
        check("mid_rst_gray",   32'(wr_gray_ptr_o),  32'(0));
        check("mid_rst_ptr",    32'(mem_wr_ptr_o),   32'(0));
        req0_valid_i  = 1'b0;
        rd_gray_ptr_i = '0;
        @(negedge wr_clk_i);
        rst_n_i = 1'b1;
        model_reset();
        step(1'b1, 8'hD0, 1'b0, '0);
        check("post_rst_first_write", 32'(wr_cnt), 32'(1));
        step(1'b1, 8'hD1, 1'b0, '0);
        idle(2);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
